// File: rtl/ysyx_23060201_dmem_responder_if.sv
// Load/store port between the execute unit (master) and the data-memory
// responder (slave).
//   req_valid/req_ready  request handshake (master -> slave)
//   mem_wen/waddr/wmask/wdata  store request fields
//   mem_ren/raddr/rmask        load request fields (rmask[4] = sign-extend)
//   rsp_valid/rsp_ready  response handshake (slave -> master)
//   mem_rdata/rsp_err    response payload
interface ysyx_23060201_dmem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [7:0]            mem_wmask;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [7:0]            mem_rmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, mem_wen, mem_waddr, mem_wmask, mem_wdata,
           mem_ren, mem_raddr, mem_rmask, rsp_ready,
    input  req_ready, rsp_valid, mem_rdata, rsp_err
  );

  modport slave (
    input  req_valid, mem_wen, mem_waddr, mem_wmask, mem_wdata,
           mem_ren, mem_raddr, mem_rmask, rsp_ready,
    output req_ready, rsp_valid, mem_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_23060201_dmem_responder.sv
// Data-memory responder: slave end of the execute unit's load/store port.
// Accepts one request per handshake, answers LATENCY cycles later with
// byte-lane masked stores and sign/zero-extended loads from a word array.
//   clk  rising-edge clock
//   rst  synchronous active-high reset (storage array is not cleared)
//   bus  slave modport: request fields, response handshake and payload
module ysyx_23060201_dmem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input logic clk,
  input logic rst,
  ysyx_23060201_dmem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  // Latched request
  logic                  lat_wen;
  logic                  lat_ren;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [4:0]            lat_mask;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Request currently being evaluated: the live bus in IDLE (needed when
  // LATENCY=1 commits on the accept edge), the latched copy otherwise.
  logic                  cur_wen, cur_ren;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [4:0]            cur_mask;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [1:0]            off;
  logic [IDX_W-1:0]      idx;
  logic                  size_ok, acc_err;
  logic [3:0]            lanes;
  logic [DATA_WIDTH-1:0] wdata_sh, raw, ext, rd_val;
  logic                  accept, commit, do_write;

  always_comb begin
    if (state == IDLE) begin
      cur_wen   = bus.mem_wen;
      cur_ren   = bus.mem_ren;
      cur_addr  = bus.mem_wen ? bus.mem_waddr : bus.mem_raddr;
      cur_mask  = bus.mem_wen ? bus.mem_wmask[4:0] : bus.mem_rmask[4:0];
      cur_wdata = bus.mem_wdata;
    end else begin
      cur_wen   = lat_wen;
      cur_ren   = lat_ren;
      cur_addr  = lat_addr;
      cur_mask  = lat_mask;
      cur_wdata = lat_wdata;
    end

    off = cur_addr[1:0];
    idx = cur_addr[IDX_W+1:2];

    case (cur_mask[3:0])
      4'b0001: size_ok = 1'b1;
      4'b0011: size_ok = ~off[0];
      4'b1111: size_ok = (off == 2'd0);
      default: size_ok = 1'b0;
    endcase
    acc_err = (cur_wen & cur_ren) | ((cur_wen | cur_ren) & ~size_ok);

    lanes    = cur_mask[3:0] << off;
    wdata_sh = cur_wdata << {off, 3'b000};

    raw = mem[idx] >> {off, 3'b000};
    case (cur_mask[3:0])
      4'b0001: ext = {{24{cur_mask[4] & raw[7]}}, raw[7:0]};
      4'b0011: ext = {{16{cur_mask[4] & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
    rd_val = (cur_ren & ~acc_err) ? ext : '0;

    accept = bus.req_valid & req_ready_q;
    // Commit edge is the one entering RESP: the accept edge when LATENCY=1,
    // otherwise the WAIT edge where the counter steps down to zero.
    commit = ((state == IDLE) & accept & (LATENCY == 1)) |
             ((state == WAIT) & (cnt == 4'd1));
    do_write = commit & cur_wen & ~acc_err & ~rst;
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lanes[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lat_wen     <= 1'b0;
      lat_ren     <= 1'b0;
      lat_addr    <= '0;
      lat_mask    <= '0;
      lat_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_wen     <= cur_wen;
            lat_ren     <= cur_ren;
            lat_addr    <= cur_addr;
            lat_mask    <= cur_mask;
            lat_wdata   <= cur_wdata;
            req_ready_q <= 1'b0;
            cnt         <= 4'(LATENCY - 1);
            state       <= WAIT;
            if (commit) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= rd_val;
              err_q       <= acc_err;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (commit) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rd_val;
            err_q       <= acc_err;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            rdata_q     <= '0;
            err_q       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  logic unused_bits;
  assign unused_bits = ^{cur_addr[ADDR_WIDTH-1:IDX_W+2], bus.mem_wmask[7:5],
                         bus.mem_rmask[7:5]};
endmodule

// File: tb/tb_ysyx_23060201_dmem_responder.sv
module tb_ysyx_23060201_dmem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060201_dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_23060201_dmem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wmask = '0;
    bus.mem_wdata = '0;
    bus.mem_ren   = 1'b0;
    bus.mem_raddr = '0;
    bus.mem_rmask = '0;
    bus.rsp_ready = 1'b0;
  endtask

  // Stimulus only: issue one request, return payload and accept-to-valid cycles.
  task automatic do_req(input logic wen, input logic ren, input logic [31:0] addr,
                        input logic [7:0] mask, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard = 0;
    while (!bus.req_ready && guard < 50) begin tick(); guard++; end
    if (!bus.req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: got req_ready=0, want 1");
    end
    bus.req_valid = 1'b1;
    bus.mem_wen   = wen;
    bus.mem_ren   = ren;
    bus.mem_waddr = addr;
    bus.mem_raddr = addr;
    bus.mem_wmask = mask;
    bus.mem_rmask = mask;
    bus.mem_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
    rdata = bus.mem_rdata;
    err   = bus.rsp_err;
    if (!bus.rsp_valid) lat = 99;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.mem_rdata); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.rsp_err); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 1'b0, 32'h100, 8'h0F, 32'hDEADBEEF, rd, er, lat);
    n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_rsp: got err=%b rdata=%h want 0/0", er, rd); end
    n_cmp++; if (lat != LATENCY) begin n_bad++; $display("FAIL sw_latency: got %0d want %0d", lat, LATENCY); end
    do_req(1'b0, 1'b1, 32'h100, 8'h1F, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL lw: got %h err=%b want deadbeef/0", rd, er); end
    n_cmp++; if (lat != LATENCY) begin n_bad++; $display("FAIL lw_latency: got %0d want %0d", lat, LATENCY); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 1'b0, 32'h101, 8'h01, 32'h00000080, rd, er, lat);
    do_req(1'b0, 1'b1, 32'h101, 8'h11, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin n_bad++; $display("FAIL lb: got %h err=%b want ffffff80", rd, er); end
    do_req(1'b0, 1'b1, 32'h101, 8'h01, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lbu: got %h want 00000080", rd); end
    do_req(1'b0, 1'b1, 32'h100, 8'h0F, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hDEAD80EF) begin n_bad++; $display("FAIL sb_word: got %h want dead80ef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 1'b0, 32'h102, 8'h03, 32'h00001234, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sh_err: got %b want 0", er); end
    do_req(1'b0, 1'b1, 32'h102, 8'h13, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h00001234) begin n_bad++; $display("FAIL lh: got %h want 00001234", rd); end
    do_req(1'b0, 1'b1, 32'h100, 8'h13, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hFFFF80EF) begin n_bad++; $display("FAIL lh_neg: got %h want ffff80ef", rd); end
    do_req(1'b1, 1'b0, 32'h103, 8'h03, 32'h0000AAAA, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL sh_misalign: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b1, 1'b0, 32'h100, 8'h07, 32'h00000000, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL bad_mask: got err=%b want 1", er); end
    do_req(1'b0, 1'b1, 32'h101, 8'h0F, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lw_misalign: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b0, 1'b1, 32'h100, 8'h0F, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h123480EF) begin n_bad++; $display("FAIL half_word: got %h want 123480ef", rd); end
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er; int lat;
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.mem_wen   = 1'b0;
    bus.mem_ren   = 1'b1;
    bus.mem_raddr = 32'h100;
    bus.mem_rmask = 8'h0F;
    tick();
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && guard < 40) begin tick(); guard++; end
    for (int i = 0; i < 5; i++) begin
      // Store attempts must be ignored while the response is held.
      bus.req_valid = 1'b1;
      bus.mem_ren   = 1'b0;
      bus.mem_wen   = 1'b1;
      bus.mem_waddr = 32'h100;
      bus.mem_wmask = 8'h0F;
      bus.mem_wdata = 32'h0;
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.mem_rdata !== 32'h123480EF || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b want 1/123480ef/0/0",
                 i, bus.rsp_valid, bus.mem_rdata, bus.rsp_err, bus.req_ready);
      end
      tick();
    end
    bus.req_valid = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
    do_req(1'b0, 1'b1, 32'h100, 8'h0F, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h123480EF) begin n_bad++; $display("FAIL stall_nowrite: got %h want 123480ef", rd); end
  endtask

  task automatic test_conflict_alias();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 1'b1, 32'h100, 8'h0F, 32'h55555555, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL wen_ren: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b0, 1'b1, 32'h100 + 4*DEPTH, 8'h0F, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h123480EF) begin n_bad++; $display("FAIL alias: got %h want 123480ef", rd); end
    do_req(1'b0, 1'b1, 32'h80000100, 8'h0F, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h123480EF) begin n_bad++; $display("FAIL alias_hi: got %h want 123480ef", rd); end
    do_req(1'b0, 1'b0, 32'h100, 8'h0F, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL noop: got rdata=%h err=%b want 0/0", rd, er); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 1'b0, 32'h200, 8'h0F, 32'hCAFEF00D, rd, er, lat);
    bus.req_valid = 1'b1;
    bus.mem_wen   = 1'b1;
    bus.mem_ren   = 1'b0;
    bus.mem_waddr = 32'h200;
    bus.mem_wmask = 8'h0F;
    bus.mem_wdata = 32'h11111111;
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid: got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid); end
    do_req(1'b0, 1'b1, 32'h200, 8'h0F, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rst_nowrite: got %h want cafef00d", rd); end
  endtask

  initial begin
    idle_bus();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_stall();
    test_conflict_alias();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
